// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: reset level, address width,
// per-stage stall bit positions, the canned stall vectors and the FSM encoding.
package pipe_ctrl_pkg;

  localparam logic RstEnable = 1'b0;

  localparam int unsigned InstAddrBus = 32;
  localparam logic [InstAddrBus-1:0] ZeroWord = '0;

  // Stall vector bit positions, front of the pipe first
  localparam int unsigned STALL_PC  = 0;
  localparam int unsigned STALL_IF  = 1;
  localparam int unsigned STALL_ID  = 2;
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = STALL_MEM + 1;
  localparam int unsigned STALL_W   = STALL_WB + 1;

  // Load-use holds PC/IF/ID; a busy EX additionally holds EX. MEM/WB always drain.
  localparam logic [STALL_W-1:0] STALL_NONE   = '0;
  localparam logic [STALL_W-1:0] STALL_ID_VEC = (STALL_W'(1) << STALL_PC)
                                              | (STALL_W'(1) << STALL_IF)
                                              | (STALL_W'(1) << STALL_ID);
  localparam logic [STALL_W-1:0] STALL_EX_VEC = STALL_ID_VEC | (STALL_W'(1) << STALL_EX);

  typedef enum logic [1:0] {
    PCTRL_RUN   = 2'd0,
    PCTRL_STALL = 2'd1,
    PCTRL_FLUSH = 2'd2
  } pctrl_state_e;

  // Winner of the per-cycle priority arbitration
  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_ID    = 2'd1,
    REQ_EX    = 2'd2,
    REQ_FLUSH = 2'd3
  } req_sel_e;

endpackage

// File: rtl/pipe_stall_timer.sv
// Stall duration monitor.
//  clk, rst         : clock, asynchronous active-low reset
//  stall            : pipeline front is held this cycle (stall_o[0])
//  flush            : pipeline is flushed this cycle; ends any stall run
//  stall_timeout_o  : sticky, set once a run reaches STALL_TIMEOUT cycles
//  stall_cycles_o   : saturating total of stalled cycles
module pipe_stall_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 64,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  output logic             stall_timeout_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam int unsigned RUN_W = (STALL_TIMEOUT > 2) ? $clog2(STALL_TIMEOUT) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_TIMEOUT - 1);

  logic [RUN_W-1:0] run_len;
  logic             counting;

  assign counting = stall && !flush;

  // run_len counts completed stall cycles of the current run; when it already
  // holds STALL_TIMEOUT-1 and the stall persists, this edge is the timeout-th.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      run_len         <= '0;
      stall_timeout_o <= 1'b0;
      stall_cycles_o  <= '0;
    end else begin
      if (!counting) begin
        run_len <= '0;
      end else if (run_len != RUN_MAX) begin
        run_len <= run_len + RUN_W'(1);
      end

      if (counting && run_len == RUN_MAX) begin
        stall_timeout_o <= 1'b1;
      end

      if (counting && stall_cycles_o != '1) begin
        stall_cycles_o <= stall_cycles_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller for the 5-stage core.
//  clk, rst         : clock, asynchronous active-low reset
//  stallreq_id_i    : ID load-use stall request
//  stallreq_ex_i    : EX multi-cycle busy stall request
//  branch_flag_i    : ID resolved a taken branch/jump
//  flush_req_i      : exception/redirect from MEM, target in flush_pc_i
//  stall_o          : {wb,mem,ex,id,if,pc} hold enables
//  flush_o/new_pc_o : clear pipeline and redirect PC
//  in_delayslot_o   : instruction in ID is a delay-slot instruction
//  stall_timeout_o  : sticky stall watchdog
//  stall_cycles_o   : saturating stalled-cycle count
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 64,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned FLUSH_MASK    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallreq_id_i,
  input  logic                   stallreq_ex_i,
  input  logic                   branch_flag_i,
  input  logic                   flush_req_i,
  input  logic [InstAddrBus-1:0] flush_pc_i,
  output logic [STALL_W-1:0]     stall_o,
  output logic                   flush_o,
  output logic [InstAddrBus-1:0] new_pc_o,
  output logic                   in_delayslot_o,
  output logic                   stall_timeout_o,
  output logic [CNT_W-1:0]       stall_cycles_o
);

  pctrl_state_e state, state_nxt;
  req_sel_e     sel;
  logic [1:0]   mask_cnt;

  // Priority arbitration; combinational outputs are forced quiet while in reset
  always_comb begin
    sel = REQ_NONE;
    if (rst != RstEnable) begin
      if (flush_req_i) begin
        sel = REQ_FLUSH;
      end else if (stallreq_ex_i) begin
        sel = REQ_EX;
      end else if (stallreq_id_i && mask_cnt == 2'd0) begin
        sel = REQ_ID;
      end
    end
  end

  always_comb begin
    stall_o  = STALL_NONE;
    flush_o  = 1'b0;
    new_pc_o = ZeroWord;
    case (sel)
      REQ_FLUSH: begin
        flush_o  = 1'b1;
        new_pc_o = flush_pc_i;
      end
      REQ_EX:   stall_o = STALL_EX_VEC;
      REQ_ID:   stall_o = STALL_ID_VEC;
      default:  ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PCTRL_RUN, PCTRL_STALL: begin
        if (sel == REQ_FLUSH) begin
          state_nxt = PCTRL_FLUSH;
        end else if (sel != REQ_NONE) begin
          state_nxt = PCTRL_STALL;
        end else begin
          state_nxt = PCTRL_RUN;
        end
      end
      PCTRL_FLUSH: begin
        state_nxt = (sel == REQ_FLUSH) ? PCTRL_FLUSH : PCTRL_RUN;
      end
      default: state_nxt = PCTRL_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state <= PCTRL_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Loaded on the edge that enters FLUSH, so the FLUSH cycle itself is the
  // first masked cycle and FLUSH_MASK cycles in total ignore the ID request.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      mask_cnt <= 2'd0;
    end else if (sel == REQ_FLUSH) begin
      mask_cnt <= 2'(FLUSH_MASK);
    end else if (mask_cnt != 2'd0) begin
      mask_cnt <= mask_cnt - 2'd1;
    end
  end

  // A branch seen while ID is held is dropped; ID presents it again on release.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      in_delayslot_o <= 1'b0;
    end else if (flush_o) begin
      in_delayslot_o <= 1'b0;
    end else if (!stall_o[STALL_ID]) begin
      in_delayslot_o <= branch_flag_i;
    end
  end

  pipe_stall_timer #(
    .STALL_TIMEOUT (STALL_TIMEOUT),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall_o[STALL_PC]),
    .flush           (flush_o),
    .stall_timeout_o (stall_timeout_o),
    .stall_cycles_o  (stall_cycles_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id_i, stallreq_ex_i, branch_flag_i, flush_req_i;
  logic [31:0] flush_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        in_delayslot_o;
  logic        stall_timeout_o;
  logic [3:0]  stall_cycles_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .STALL_TIMEOUT (4),
    .CNT_W         (4),
    .FLUSH_MASK    (1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_id_i   (stallreq_id_i),
    .stallreq_ex_i   (stallreq_ex_i),
    .branch_flag_i   (branch_flag_i),
    .flush_req_i     (flush_req_i),
    .flush_pc_i      (flush_pc_i),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .new_pc_o        (new_pc_o),
    .in_delayslot_o  (in_delayslot_o),
    .stall_timeout_o (stall_timeout_o),
    .stall_cycles_o  (stall_cycles_o)
  );

  typedef struct {
    logic        id, ex, br, fl;
    logic [31:0] pc;
    logic [5:0]  exp_stall;
    logic        exp_flush;
    logic [31:0] exp_npc;
    logic        exp_ds;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic id, input logic ex, input logic br, input logic fl,
                       input logic [31:0] pc);
    @(negedge clk);
    stallreq_id_i = id;
    stallreq_ex_i = ex;
    branch_flag_i = br;
    flush_req_i   = fl;
    flush_pc_i    = pc;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    stallreq_id_i = 1'b0;
    stallreq_ex_i = 1'b0;
    branch_flag_i = 1'b0;
    flush_req_i   = 1'b0;
    flush_pc_i    = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic id, input logic ex, input logic br,
                         input logic fl, input logic [31:0] pc, input logic [5:0] es,
                         input logic ef, input logic [31:0] enp, input logic eds);
    vecs[i].id = id; vecs[i].ex = ex; vecs[i].br = br; vecs[i].fl = fl; vecs[i].pc = pc;
    vecs[i].exp_stall = es; vecs[i].exp_flush = ef; vecs[i].exp_npc = enp; vecs[i].exp_ds = eds;
  endtask

  initial begin
    //       i   id ex br fl pc            stall     fl npc           ds
    set_vec(0,  0, 0, 0, 0, 32'h0,        6'h00,    0, 32'h0,        0);
    set_vec(1,  0, 0, 1, 0, 32'h0,        6'h00,    0, 32'h0,        1);
    set_vec(2,  0, 0, 0, 0, 32'h0,        6'h00,    0, 32'h0,        0);
    set_vec(3,  1, 0, 1, 0, 32'h0,        6'b000111,0, 32'h0,        0);
    set_vec(4,  0, 0, 1, 0, 32'h0,        6'h00,    0, 32'h0,        1);
    set_vec(5,  0, 1, 0, 0, 32'h0,        6'b001111,0, 32'h0,        1);
    set_vec(6,  1, 1, 0, 0, 32'h0,        6'b001111,0, 32'h0,        1);
    set_vec(7,  0, 1, 0, 1, 32'h40,       6'h00,    1, 32'h40,       0);
    set_vec(8,  1, 0, 0, 0, 32'h0,        6'h00,    0, 32'h0,        0);
    set_vec(9,  1, 0, 1, 0, 32'h0,        6'b000111,0, 32'h0,        0);
    set_vec(10, 0, 0, 0, 1, 32'h80,       6'h00,    1, 32'h80,       0);
    set_vec(11, 0, 0, 0, 1, 32'h100,      6'h00,    1, 32'h100,      0);
    set_vec(12, 0, 1, 0, 0, 32'h0,        6'b001111,0, 32'h0,        0);
    set_vec(13, 1, 0, 0, 0, 32'h0,        6'b000111,0, 32'h0,        0);
    set_vec(14, 0, 0, 1, 0, 32'h0,        6'h00,    0, 32'h0,        1);
    set_vec(15, 1, 0, 1, 1, 32'hDEADBEEC, 6'h00,    1, 32'hDEADBEEC, 0);

    do_reset();

    // Reset mid-stall
    for (int k = 1; k <= 5; k++) begin
      drive(0, 1, 0, 0, 32'h0);
      check("midstall_stall", 32'(stall_o), 32'h0F);
      tick();
    end
    check("midstall_cycles", 32'(stall_cycles_o), 32'd5);
    check("midstall_timeout", 32'(stall_timeout_o), 32'd1);
    drive(0, 1, 0, 1, 32'h40);
    rst = 1'b0;
    #1;
    check("rst_stall", 32'(stall_o), 32'h0);
    check("rst_flush", 32'(flush_o), 32'h0);
    check("rst_newpc", new_pc_o, 32'h0);
    check("rst_ds", 32'(in_delayslot_o), 32'h0);
    check("rst_timeout", 32'(stall_timeout_o), 32'h0);
    check("rst_cycles", 32'(stall_cycles_o), 32'h0);
    do_reset();

    // Load-use single cycle
    drive(1, 0, 0, 0, 32'h0);
    check("loaduse_stall", 32'(stall_o), 32'b000111);
    check("loaduse_cyc0", 32'(stall_cycles_o), 32'd0);
    tick();
    check("loaduse_cyc1", 32'(stall_cycles_o), 32'd1);

    // Table: priority, masking, delay slot
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].id, vecs[i].ex, vecs[i].br, vecs[i].fl, vecs[i].pc);
      check($sformatf("vec%0d_stall", i), 32'(stall_o), 32'(vecs[i].exp_stall));
      check($sformatf("vec%0d_flush", i), 32'(flush_o), 32'(vecs[i].exp_flush));
      check($sformatf("vec%0d_newpc", i), new_pc_o, vecs[i].exp_npc);
      tick();
      check($sformatf("vec%0d_ds", i), 32'(in_delayslot_o), 32'(vecs[i].exp_ds));
    end
    check("table_cycles", 32'(stall_cycles_o), 32'd6);
    check("table_timeout", 32'(stall_timeout_o), 32'd0);

    // Timeout: 3-cycle run stays quiet, 4-cycle run trips and sticks
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 32'h0);
      tick();
    end
    check("to3_held", 32'(stall_timeout_o), 32'd0);
    drive(0, 0, 0, 0, 32'h0);
    tick();
    check("to3_release", 32'(stall_timeout_o), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      drive(0, 1, 0, 0, 32'h0);
      tick();
      check($sformatf("to4_edge%0d", k), 32'(stall_timeout_o), (k == 4) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 32'h0);
      tick();
      check("to4_sticky", 32'(stall_timeout_o), 32'd1);
    end

    // Saturation of the 4-bit total
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      drive(0, 1, 0, 0, 32'h0);
      tick();
      check($sformatf("sat_%0d", k), 32'(stall_cycles_o), (k > 15) ? 32'd15 : 32'(k));
    end
    drive(0, 0, 0, 0, 32'h0);
    tick();
    check("sat_after", 32'(stall_cycles_o), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
